// File: rtl/zeroriscy_bnn_seq_if.sv
// rtl/zeroriscy_bnn_seq_if.sv - command, issue and result signals of the BNN sequencer
interface zeroriscy_bnn_seq_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        bnn_en_o;
  logic [2:0]  bnn_operator_o;
  logic [31:0] bnn_addr_o;
  logic [31:0] bnn_data_o;
  logic [31:0] bnn_result_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_data_o;
  logic        idle_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, bnn_result_i, res_ready_i,
    output cmd_ready_o, bnn_en_o, bnn_operator_o, bnn_addr_o, bnn_data_o,
           res_valid_o, res_data_o, idle_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, bnn_result_i, res_ready_i,
    input  cmd_ready_o, bnn_en_o, bnn_operator_o, bnn_addr_o, bnn_data_o,
           res_valid_o, res_data_o, idle_o
  );
endinterface

// File: rtl/zeroriscy_bnn_seq.sv
// rtl/zeroriscy_bnn_seq.sv - command FIFO, spaced issue and result capture for the BNN unit
module zeroriscy_bnn_seq #(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  zeroriscy_bnn_seq_if.slave bus
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam int RIW = (RAW > 0) ? RAW : 1;
  localparam int CRW = $clog2(RES_DEPTH + 1);
  localparam logic [2:0] OP_ACTIV = 3'd4;
  localparam logic [2:0] OP_IP8   = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'b100;

  typedef enum logic {S_IDLE, S_GAP} state_t;

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_gap_cnt, w_gap_cnt_nxt;
  logic [2:0]     r_cmd_op   [CMD_DEPTH];
  logic [31:0]    r_cmd_addr [CMD_DEPTH];
  logic [31:0]    r_cmd_data [CMD_DEPTH];
  logic [CAW:0]   r_cmd_wptr, r_cmd_rptr;
  logic [31:0]    r_res_mem  [RES_DEPTH];
  logic [RAW:0]   r_res_wptr, r_res_rptr;
  logic [CRW-1:0] r_credits;
  logic [1:0]     r_if_vld;
  logic [1:0]     r_if_cnt [2];

  logic           w_cmd_empty, w_cmd_full, w_push, w_issue, w_head_res, w_gate;
  logic           w_res_empty, w_pop, w_cap;
  logic [2:0]     w_head_op;
  logic [RIW-1:0] w_res_widx, w_res_ridx;

  assign w_cmd_empty = (r_cmd_wptr == r_cmd_rptr);
  assign w_cmd_full  = ((r_cmd_wptr ^ r_cmd_rptr) == (CAW+1)'(CMD_DEPTH));
  assign w_head_op   = r_cmd_op[r_cmd_rptr[CAW-1:0]];
  assign w_head_res  = (w_head_op == OP_ACTIV) || (w_head_op == OP_IP8);
  // A result-producing op may only leave once a result slot is reserved for it
  assign w_gate      = !w_head_res || (r_credits != '0);
  assign w_issue     = (r_state == S_IDLE) && !w_cmd_empty && w_gate;
  assign w_push      = bus.cmd_valid_i && bus.cmd_ready_o;

  assign w_res_empty = (r_res_wptr == r_res_rptr);
  assign w_pop       = !w_res_empty && bus.res_ready_i;
  assign w_res_widx  = RIW'(r_res_wptr % (RAW+1)'(RES_DEPTH));
  assign w_res_ridx  = RIW'(r_res_rptr % (RAW+1)'(RES_DEPTH));
  assign w_cap       = (r_if_vld[0] && (r_if_cnt[0] == 2'd1)) ||
                       (r_if_vld[1] && (r_if_cnt[1] == 2'd1));

  assign bus.cmd_ready_o    = !w_cmd_full || w_issue;
  assign bus.bnn_en_o       = w_issue;
  assign bus.bnn_operator_o = w_issue ? w_head_op : OP_NOP;
  assign bus.bnn_addr_o     = w_issue ? r_cmd_addr[r_cmd_rptr[CAW-1:0]] : 32'd0;
  assign bus.bnn_data_o     = w_issue ? r_cmd_data[r_cmd_rptr[CAW-1:0]] : 32'd0;
  assign bus.res_valid_o    = !w_res_empty;
  assign bus.res_data_o     = w_res_empty ? 32'd0 : r_res_mem[w_res_ridx];
  assign bus.idle_o         = w_cmd_empty && (r_state == S_IDLE) && (r_if_vld == 2'b00);

  always_comb begin
    w_state_nxt   = r_state;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_issue && (w_head_op == OP_ACTIV)) begin
          w_state_nxt   = S_GAP;
          w_gap_cnt_nxt = 2'd2;
        end else if (w_issue && (w_head_op == OP_IP8)) begin
          w_state_nxt   = S_GAP;
          w_gap_cnt_nxt = 2'd3;
        end
      end
      S_GAP: begin
        w_gap_cnt_nxt = r_gap_cnt - 2'd1;
        if (r_gap_cnt == 2'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gap_cnt  <= 2'd0;
      r_cmd_wptr <= '0;
      r_cmd_rptr <= '0;
      r_res_wptr <= '0;
      r_res_rptr <= '0;
      r_credits  <= CRW'(RES_DEPTH);
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      if (w_push)  r_cmd_wptr <= r_cmd_wptr + 1'b1;
      if (w_issue) r_cmd_rptr <= r_cmd_rptr + 1'b1;
      if (w_cap)   r_res_wptr <= r_res_wptr + 1'b1;
      if (w_pop)   r_res_rptr <= r_res_rptr + 1'b1;
      r_credits <= r_credits - CRW'(w_issue && w_head_res) + CRW'(w_pop);
    end
  end

  // Countdown equals cycles left until the result bus is sampled; slot 1 takes the aged slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_vld <= 2'b00;
      for (int i = 0; i < 2; i++) r_if_cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_if_vld[i]) begin
          r_if_cnt[i] <= r_if_cnt[i] - 2'd1;
          if (r_if_cnt[i] == 2'd1) r_if_vld[i] <= 1'b0;
        end
      end
      if (w_issue && w_head_res) begin
        r_if_vld[0] <= 1'b1;
        r_if_cnt[0] <= (w_head_op == OP_ACTIV) ? 2'd2 : 2'd3;
        r_if_vld[1] <= r_if_vld[0] && (r_if_cnt[0] != 2'd1);
        r_if_cnt[1] <= r_if_cnt[0] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cmd_op[r_cmd_wptr[CAW-1:0]]   <= bus.cmd_op_i;
      r_cmd_addr[r_cmd_wptr[CAW-1:0]] <= bus.cmd_addr_i;
      r_cmd_data[r_cmd_wptr[CAW-1:0]] <= bus.cmd_data_i;
    end
    if (w_cap) r_res_mem[w_res_widx] <= bus.bnn_result_i;
  end
endmodule

// File: tb/tb_zeroriscy_bnn_seq.sv
// tb/tb_zeroriscy_bnn_seq.sv - directed, table and random checks of zeroriscy_bnn_seq against a queue model
module tb_zeroriscy_bnn_seq;
  localparam int CMD_DEPTH = 4;
  localparam int RES_DEPTH = 2;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;
  typedef struct {
    int   t;
    cmd_t c;
  } iss_t;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_gap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cmd_t        mq[$];
  logic [31:0] mres[$];
  int          mcap[$];
  int          m_credits, m_now, m_next_ok;
  iss_t        ilog[$];
  logic        lrv[int];
  logic [31:0] lrd[int];
  logic [31:0] lri[int];
  vec_t        tbl[8];

  always #5 clk = ~clk;

  zeroriscy_bnn_seq_if bus ();

  zeroriscy_bnn_seq #(.CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, m_now, got, want);
    end
  endtask

  function automatic logic m_idle();
    return (mq.size() == 0) && (m_now >= m_next_ok) && (mcap.size() == 0);
  endfunction

  function automatic int find_idx(input logic [31:0] addr);
    for (int i = 0; i < ilog.size(); i++)
      if (ilog[i].c.addr == addr) return i;
    return -1;
  endfunction

  function automatic int find_issue(input logic [31:0] addr);
    int k;
    k = find_idx(addr);
    return (k < 0) ? -1 : ilog[k].t;
  endfunction

  // One clock: compare DUT against the model mid-cycle, then advance the model across the edge
  task automatic cycle();
    logic e_en, e_rdy, e_res, acc, pop;
    cmd_t h, nc;
    iss_t e;
    @(negedge clk);
    e_en  = 1'b0;
    e_res = 1'b0;
    h     = '0;
    if (mq.size() > 0) begin
      h     = mq[0];
      e_res = (h.op == 3'd4) || (h.op == 3'd5);
      e_en  = (m_now >= m_next_ok) && (!e_res || (m_credits > 0));
    end
    e_rdy = (mq.size() < CMD_DEPTH) || e_en;
    chk("bnn_en",    bus.bnn_en_o,       e_en);
    chk("bnn_op",    bus.bnn_operator_o, e_en ? h.op : 3'b100);
    chk("bnn_addr",  bus.bnn_addr_o,     e_en ? h.addr : 32'd0);
    chk("bnn_data",  bus.bnn_data_o,     e_en ? h.data : 32'd0);
    chk("cmd_ready", bus.cmd_ready_o,    e_rdy);
    chk("res_valid", bus.res_valid_o,    mres.size() > 0);
    chk("res_data",  bus.res_data_o,     (mres.size() > 0) ? mres[0] : 32'd0);
    chk("idle",      bus.idle_o,         m_idle());
    lrv[m_now] = bus.res_valid_o;
    lrd[m_now] = bus.res_data_o;
    lri[m_now] = bus.bnn_result_i;
    if (bus.bnn_en_o) begin
      e.t      = m_now;
      e.c.op   = bus.bnn_operator_o;
      e.c.addr = bus.bnn_addr_o;
      e.c.data = bus.bnn_data_o;
      ilog.push_back(e);
    end
    acc = bus.cmd_valid_i && e_rdy;
    pop = (mres.size() > 0) && bus.res_ready_i;
    if (e_en) begin
      void'(mq.pop_front());
      if (h.op == 3'd4) begin
        m_next_ok = m_now + 3;
        m_credits--;
        mcap.push_back(m_now + 2);
      end else if (h.op == 3'd5) begin
        m_next_ok = m_now + 4;
        m_credits--;
        mcap.push_back(m_now + 3);
      end
    end
    if (acc) begin
      nc.op   = bus.cmd_op_i;
      nc.addr = bus.cmd_addr_i;
      nc.data = bus.cmd_data_i;
      mq.push_back(nc);
    end
    if ((mcap.size() > 0) && (mcap[0] == m_now)) begin
      void'(mcap.pop_front());
      mres.push_back(bus.bnn_result_i);
    end
    if (pop) begin
      void'(mres.pop_front());
      m_credits++;
    end
    m_now++;
    @(posedge clk);
    #1;
    bus.bnn_result_i = $urandom();
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_op_i     = 3'd0;
    bus.cmd_addr_i   = 32'd0;
    bus.cmd_data_i   = 32'd0;
    bus.res_ready_i  = 1'b0;
    bus.bnn_result_i = $urandom();
    #1;
    chk("rst_bnn_en",    bus.bnn_en_o,       0);
    chk("rst_bnn_op",    bus.bnn_operator_o, 3'b100);
    chk("rst_bnn_addr",  bus.bnn_addr_o,     0);
    chk("rst_bnn_data",  bus.bnn_data_o,     0);
    chk("rst_cmd_ready", bus.cmd_ready_o,    1);
    chk("rst_res_valid", bus.res_valid_o,    0);
    chk("rst_res_data",  bus.res_data_o,     0);
    chk("rst_idle",      bus.idle_o,         1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); mres.delete(); mcap.delete(); ilog.delete();
    lrv.delete(); lrd.delete(); lri.delete();
    m_credits = RES_DEPTH;
    m_now     = 0;
    m_next_ok = 0;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = data;
    cycle();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(m_idle() && (mres.size() == 0)) && (n < budget)) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, k, p;
    logic [31:0] order3 [7];

    tbl[0] = '{3'd0, 32'h1000_0010, 32'hdead_0000, 1};
    tbl[1] = '{3'd1, 32'h1000_0020, 32'hdead_0001, 1};
    tbl[2] = '{3'd2, 32'h1000_0030, 32'hdead_0002, 1};
    tbl[3] = '{3'd3, 32'h1000_0040, 32'hdead_0003, 1};
    tbl[4] = '{3'd4, 32'h1000_0050, 32'hdead_0004, 3};
    tbl[5] = '{3'd5, 32'h1000_0060, 32'hdead_0005, 4};
    tbl[6] = '{3'd6, 32'h1000_0070, 32'hdead_0006, 1};
    tbl[7] = '{3'd7, 32'h1000_0080, 32'hdead_0007, 1};
    order3 = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hD1, 32'hD2, 32'hE0};

    #2;
    do_reset();

    // back-to-back ordinary ops issue one per cycle from the cycle after the first push
    for (int i = 0; i < 4; i++) push(3'd1, 32'h100 + i, 32'h200 + i);
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) chk("t1_issue_cycle", find_issue(32'h100 + i), i + 1);

    // IP8 spacing and capture point
    do_reset();
    push(3'd5, 32'h0102_0300, 32'd0);
    push(3'd1, 32'h0000_0222, 32'd0);
    repeat (8) cycle();
    t = find_issue(32'h0102_0300);
    chk("t2_op5_issue", t, 1);
    chk("t2_spacing", find_issue(32'h0000_0222) - t, 4);
    chk("t2_rv_before", lrv[t + 3], 0);
    chk("t2_rv_rise",   lrv[t + 4], 1);
    chk("t2_res_data",  lrd[t + 4], lri[t + 3]);

    // credit exhaustion holds the third ACTIV; full FIFO accepts a push on the issue cycle
    do_reset();
    push(3'd4, 32'hA0, 32'd1);
    push(3'd4, 32'hB0, 32'd2);
    push(3'd4, 32'hC0, 32'd3);
    repeat (6) cycle();
    for (int i = 0; i < 3; i++) push(3'd1, 32'hD0 + i, i);
    repeat (3) cycle();
    chk("t3_held_en",    bus.bnn_en_o,    0);
    chk("t3_full_ready", bus.cmd_ready_o, 0);
    p = m_now;
    bus.res_ready_i = 1'b1;
    cycle();
    bus.res_ready_i = 1'b0;
    push(3'd1, 32'hE0, 32'd9);
    bus.res_ready_i = 1'b1;
    drain(200);
    chk("t3_issue_after_pop", find_issue(32'hC0), p + 1);
    chk("t4_issue_count", ilog.size(), 7);
    for (int i = 0; i < 7; i++) begin
      k = (i < ilog.size()) ? i : 0;
      chk("t4_issue_order", (i < ilog.size()) ? ilog[k].c.addr : 32'hffff_ffff, order3[i]);
    end

    // per-operator issue spacing from a table of single commands
    do_reset();
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].op, tbl[i].addr, tbl[i].data);
      push(3'd1, 32'hF000 + i, 32'd0);
      drain(100);
      k = find_idx(tbl[i].addr);
      chk("tbl_found", k >= 0, 1);
      if (k >= 0) begin
        chk("tbl_op",   ilog[k].c.op,   tbl[i].op);
        chk("tbl_data", ilog[k].c.data, tbl[i].data);
        chk("tbl_gap",  find_issue(32'hF000 + i) - ilog[k].t, tbl[i].exp_gap);
      end
    end

    // reset one cycle after an IP8 issue drops the in-flight result
    do_reset();
    push(3'd5, 32'h5555, 32'd0);
    cycle();
    do_reset();
    bus.res_ready_i = 1'b1;
    repeat (6) cycle();
    chk("t5_no_result", bus.res_valid_o, 0);
    chk("t5_idle",      bus.idle_o,      1);

    // random stream against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.cmd_valid_i = 1'($urandom_range(0, 1));
      bus.cmd_op_i    = 3'($urandom_range(0, 7));
      bus.cmd_addr_i  = $urandom();
      bus.cmd_data_i  = $urandom();
      bus.res_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.cmd_valid_i = 1'b0;
    bus.res_ready_i = 1'b1;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
